// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles 32-bit words,
// writes them to IMEM and holds the CPU in reset until loaded.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_reset
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH+1:0] MEM_WORDS =
    {2'b01, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH+1:0] BASE_EXT =
    (ADDR_WIDTH+2)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE_A =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
  localparam logic [ADDR_WIDTH:0]   ONE_L = 1;

  state_t                state;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            byte_idx;
  logic [31:0]           word;

  logic                  len_bad;
  logic                  accept;
  logic [1:0]            lane;
  logic [31:0]           word_nxt;

  always_comb begin
    len_bad  = (len == '0) ||
               ((BASE_EXT + {1'b0, len}) > MEM_WORDS);
    accept   = in_valid && in_ready;
    lane     = BIG_ENDIAN ? (2'd3 - byte_idx) : byte_idx;
    word_nxt = word;
    word_nxt[{lane, 3'b000} +: 8] = in_data;
  end

  // outputs are set from the next state so they stay registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      addr      <= BASE_A;
      byte_idx  <= '0;
      word      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_A;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      error  <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (len_bad) begin
              error <= 1'b1;
            end else begin
              remaining <= len;
              addr      <= BASE_A;
              byte_idx  <= '0;
              word      <= '0;
              done      <= 1'b0;
              cpu_reset <= 1'b1;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
              state     <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (start) error <= 1'b1;
          if (accept) begin
            word     <= word_nxt;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= word_nxt;
              state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (start) error <= 1'b1;
          addr      <= addr + ONE_A;
          remaining <= remaining - ONE_L;
          byte_idx  <= '0;
          if (remaining == ONE_L) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
            state     <= S_DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= S_COLLECT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: big-endian instance at base 0,
// little-endian instance at base 4, driven by the same stream.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic       be_in_ready, be_mem_we, be_busy, be_done, be_error, be_cpu_reset;
  logic [7:0] be_mem_addr;
  logic [31:0] be_mem_wdata;
  logic       le_in_ready, le_mem_we, le_busy, le_done, le_error, le_cpu_reset;
  logic [7:0] le_mem_addr;
  logic [31:0] le_mem_wdata;

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(be_in_ready),
    .mem_we(be_mem_we), .mem_addr(be_mem_addr), .mem_wdata(be_mem_wdata),
    .busy(be_busy), .done(be_done), .error(be_error),
    .cpu_reset(be_cpu_reset)
  );

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(4), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(le_in_ready),
    .mem_we(le_mem_we), .mem_addr(le_mem_addr), .mem_wdata(le_mem_wdata),
    .busy(le_busy), .done(le_done), .error(le_error),
    .cpu_reset(le_cpu_reset)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [39:0] be_q[$];
  logic [39:0] le_q[$];
  int ir_viol = 0;
  int be_err = 0;
  int le_err = 0;

  always @(negedge clk) begin
    if (be_mem_we) begin
      be_q.push_back({be_mem_addr, be_mem_wdata});
      if (be_in_ready) ir_viol++;
    end
    if (le_mem_we) begin
      le_q.push_back({le_mem_addr, le_mem_wdata});
      if (le_in_ready) ir_viol++;
    end
    if (be_error) be_err++;
    if (le_error) le_err++;
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_start(input logic [8:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap,
                           output int unsigned acc);
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!be_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic wait_done(output int unsigned at);
    int n;
    n = 0;
    while (!(be_done && le_done) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", {31'b0, be_done && le_done}, 32'd1);
    at = cyc;
  endtask

  task automatic check_writes(input string tag, input int n,
                              input logic [95:0] bew,
                              input logic [95:0] lew);
    logic [39:0] e;
    chk({tag, "_be_count"}, be_q.size(), n);
    chk({tag, "_le_count"}, le_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (be_q.size() > 0) begin
        e = be_q.pop_front();
        chk({tag, "_be_addr"}, {24'b0, e[39:32]}, i);
        chk({tag, "_be_data"}, e[31:0], bew[95-32*i -: 32]);
      end
      if (le_q.size() > 0) begin
        e = le_q.pop_front();
        chk({tag, "_le_addr"}, {24'b0, e[39:32]}, 4 + i);
        chk({tag, "_le_data"}, e[31:0], lew[95-32*i -: 32]);
      end
    end
    be_q.delete();
    le_q.delete();
  endtask

  typedef struct packed {
    logic [1:0]  len;
    logic        gaps;
    logic [95:0] bytes;
    logic [95:0] be_words;
    logic [95:0] le_words;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned acc, first, at;
    logic [95:0] bb;
    logic [95:0] t1b;

    vecs[0] = '{len: 2'd1, gaps: 1'b0,
      bytes:    96'h78563412_00000000_00000000,
      be_words: 96'h78563412_00000000_00000000,
      le_words: 96'h12345678_00000000_00000000};
    vecs[1] = '{len: 2'd3, gaps: 1'b1,
      bytes:    96'h01020304_05060708_090A0B0C,
      be_words: 96'h01020304_05060708_090A0B0C,
      le_words: 96'h04030201_08070605_0C0B0A09};
    vecs[2] = '{len: 2'd2, gaps: 1'b1,
      bytes:    96'h3C080010_20080005_00000000,
      be_words: 96'h3C080010_20080005_00000000,
      le_words: 96'h1000083C_05000820_00000000};
    vecs[3] = '{len: 2'd3, gaps: 1'b0,
      bytes:    96'hDEADBEEF_00FF807F_A55AC33C,
      be_words: 96'hDEADBEEF_00FF807F_A55AC33C,
      le_words: 96'hEFBEADDE_7F80FF00_3CC35AA5};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_in_ready", be_in_ready, 0);
    chk("rst_mem_we", be_mem_we, 0);
    chk("rst_be_addr", be_mem_addr, 0);
    chk("rst_le_addr", le_mem_addr, 4);
    chk("rst_wdata", be_mem_wdata, 0);
    chk("rst_busy", be_busy, 0);
    chk("rst_done", be_done, 0);
    chk("rst_error", be_error, 0);
    chk("rst_cpu_reset", be_cpu_reset, 1);

    // rejected lengths from IDLE
    do_start(9'd0);
    chk("len0_err_be", be_error, 1);
    chk("len0_err_le", le_error, 1);
    @(negedge clk);
    chk("len0_err_pulse", be_error, 0);
    chk("len0_busy", be_busy, 0);
    chk("len0_cpu_reset", be_cpu_reset, 1);
    do_start(9'd257);
    chk("len257_err_be", be_error, 1);
    chk("len257_err_le", le_error, 1);
    @(negedge clk);
    chk("len257_err_pulse", le_error, 0);
    chk("len257_in_ready", be_in_ready, 0);
    chk("len257_cpu_reset", le_cpu_reset, 1);
    in_valid = 1'b1;
    in_data  = 8'h99;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_no_write", be_q.size() + le_q.size(), 0);

    // two-word back-to-back load with latency check
    do_start(9'd2);
    chk("t1_busy", be_busy, 1);
    chk("t1_in_ready", be_in_ready, 1);
    t1b = 96'h3C080010_20080005_00000000;
    first = 0;
    for (int i = 0; i < 8; i++) begin
      send_byte(t1b[95-8*i -: 8], 0, acc);
      if (i == 0) first = acc;
      if (i == 2) chk("t1_cpu_reset_held", be_cpu_reset, 1);
    end
    in_valid = 1'b0;
    wait_done(at);
    chk("t1_done_latency", at - first, 9);
    chk("t1_cpu_reset", be_cpu_reset, 0);
    chk("t1_busy_end", be_busy, 0);
    check_writes("t1", 2, 96'h3C080010_20080005_00000000,
                 96'h1000083C_05000820_00000000);

    for (int k = 0; k < 4; k++) begin
      do_start({7'b0, vecs[k].len});
      chk("vec_done_cleared", be_done, 0);
      bb = vecs[k].bytes;
      for (int i = 0; i < 4 * int'(vecs[k].len); i++)
        send_byte(bb[95-8*i -: 8],
                  vecs[k].gaps ? int'($urandom_range(0, 3)) : 0, acc);
      in_valid = 1'b0;
      wait_done(at);
      chk("vec_cpu_reset", le_cpu_reset, 0);
      check_writes("vec", int'(vecs[k].len), vecs[k].be_words,
                   vecs[k].le_words);
    end

    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("done_no_accept", be_q.size() + le_q.size(), 0);
    chk("done_in_ready", be_in_ready, 0);

    do_start(9'd0);
    chk("done_err", be_error, 1);
    chk("done_err_keeps_done", be_done, 1);

    // start during a load is rejected, load continues
    @(negedge clk);
    do_start(9'd2);
    t1b = 96'hA1B2C3D4_E5F60718_00000000;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start = 1'b1;
        len   = 9'd1;
      end
      send_byte(t1b[95-8*i -: 8], 0, acc);
      if (i == 2) begin
        start = 1'b0;
        chk("mid_err", be_error, 1);
        chk("mid_busy", be_busy, 1);
      end
    end
    in_valid = 1'b0;
    wait_done(at);
    check_writes("mid", 2, 96'hA1B2C3D4_E5F60718_00000000,
                 96'hD4C3B2A1_1807F6E5_00000000);

    // async reset after two bytes
    do_start(9'd1);
    send_byte(8'hAA, 0, acc);
    send_byte(8'hBB, 0, acc);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_in_ready", be_in_ready, 0);
    chk("arst_busy", be_busy, 0);
    chk("arst_done", be_done, 0);
    chk("arst_cpu_reset", be_cpu_reset, 1);
    chk("arst_mem_we", be_mem_we, 0);
    chk("arst_wdata", be_mem_wdata, 0);
    chk("arst_le_addr", le_mem_addr, 4);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst_no_write", be_q.size() + le_q.size(), 0);
    do_start(9'd1);
    t1b = 96'h11223344_00000000_00000000;
    for (int i = 0; i < 4; i++) send_byte(t1b[95-8*i -: 8], 0, acc);
    in_valid = 1'b0;
    wait_done(at);
    check_writes("arst", 1, 96'h11223344_00000000_00000000,
                 96'h44332211_00000000_00000000);

    chk("in_ready_in_write", ir_viol, 0);
    chk("be_error_pulses", be_err, 4);
    chk("le_error_pulses", le_err, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
